// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bin2bcd_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam int unsigned DIGIT_W = 4;

  // Active-high segments in gfedcba order, index 9 first so SEG_LUT[d] is digit d.
  localparam logic [9:0][6:0] SEG_LUT = {
    7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  // Non-decimal codes never occur in a converted result; they map to blank.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    return (d > 4'd9) ? 7'b0 : SEG_LUT[d];
  endfunction

endpackage

// File: rtl/bin2bcd_seq_add3.sv
// Double-dabble correction cell: adds 3 to a BCD digit of 5 or more so the
// following left shift carries correctly into the next decade.
module bcd_add3 (
  input  logic [3:0] digit,
  output logic [3:0] adjusted
);

  assign adjusted = (digit >= 4'd5) ? digit + 4'd3 : digit;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter, one shift-add-3 iteration per clock.
// Started by a rising edge on in_valid; bcd is updated together with a
// one-cycle done pulse. Optional 7-segment output under BIN2BCD_SEG_EN.
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           bin,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(WIDTH+1)-1:0] count,
  output logic [4*DIGITS-1:0]        bcd
`ifdef BIN2BCD_SEG_EN
  ,
  output logic [7*DIGITS-1:0]        seg
`endif
);

  localparam int CW  = $clog2(WIDTH + 1);
  localparam int DW  = DIGIT_W * DIGITS;
  localparam int SRW = DW + WIDTH;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t         state;
  logic           prev;
  logic           start;
  logic [SRW-1:0] sr;
  logic [DW-1:0]  adj;

  assign start = in_valid & ~prev;

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .digit    (sr[WIDTH + g*DIGIT_W +: DIGIT_W]),
      .adjusted (adj[g*DIGIT_W +: DIGIT_W])
    );
  end

`ifdef BIN2BCD_SEG_EN
  logic [7*DIGITS-1:0] seg_nxt;

  // Encode the finished digit field, blanking zeros above the first non-zero digit.
  always_comb begin
    logic        blank;
    logic [3:0]  d;
    int unsigned idx;
    seg_nxt = '0;
    blank   = 1'b1;
    d       = '0;
    idx     = 0;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      idx = DIGITS - 1 - k;
      d   = sr[WIDTH + idx*DIGIT_W +: DIGIT_W];
      if (d != 4'd0 || idx == 0) blank = 1'b0;
      seg_nxt[idx*7 +: 7] = blank ? 7'b0 : seg7(d);
    end
  end
`endif

  // Control FSM, edge detector, shift register and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      prev  <= 1'b0;
      sr    <= '0;
      count <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      bcd   <= '0;
`ifdef BIN2BCD_SEG_EN
      seg   <= '0;
`endif
    end else begin
      prev <= in_valid;
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sr    <= {{DW{1'b0}}, bin};
            count <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          // Correction is applied to the digit field before the shift, as one step.
          sr    <= {adj, sr[WIDTH-1:0]} << 1;
          count <= count + CW'(1);
          if (count == LAST) state <= DONE;
        end
        DONE: begin
          bcd   <= sr[SRW-1 -: DW];
`ifdef BIN2BCD_SEG_EN
          seg   <= seg_nxt;
`endif
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
